spw_link_fsm: RTL and testbench
===============================

// Module: spw_link_fsm
// PURPOSE
//  SpaceWire link-interface state machine (ECSS-E-ST-50-12C 8.5). Sequences the
//  receive token detector and the transmitter through ErrorReset..Run using the
//  detector's got_*/error events, and enforces receive credit.
//  Sits between the rx token detector, the tx encoder and the host config regs.
// PARAMETERS
//  T_6U4   640  cycles of pclk = 6.4us (ErrorReset dwell)
//  T_12U8  1280 cycles of pclk = 12.8us (ErrorWait dwell; Started/Connecting timeout)
//  T_DISC  85   cycles of pclk without rx_got_bit = disconnect (850ns)
// PORTS
//  pclk            in  1  system clock
//  reset           in  1  synchronous, active-high
//  link_start      in  1  host: start link (level)
//  auto_start      in  1  host: start on first received NULL (level)
//  link_disable    in  1  host: force link down (level)
//  rx_got_bit      in  1  pulse: detector saw a bit edge
//  rx_got_null     in  1  pulse: NULL received
//  rx_got_fct      in  1  pulse: FCT received
//  rx_got_nchar    in  1  pulse: N-Char received
//  rx_got_time_code in 1  pulse: time-code received
//  rx_error        in  1  level: parity/escape error from detector
//  tx_fct_sent     in  1  pulse: tx sent one FCT (grants 8 rx credits)
//  rx_resetn       out 1  active-low reset to rx detector
//  tx_enable       out 1  tx may send NULLs
//  tx_fct_enable   out 1  tx may send FCTs
//  tx_data_enable  out 1  tx may send N-Chars/time-codes
//  link_state      out 3  0 ErrRst,1 ErrWait,2 Ready,3 Started,4 Connecting,5 Run
//  link_running    out 1  state==Run
//  link_error      out 1  one-cycle pulse on any transition into ErrorReset
//  credit_error    out 1  one-cycle pulse on credit violation
//  rx_credit       out 6  outstanding rx credit, 0..56
// BEHAVIOUR
//  - All inputs synchronous to pclk; got_* are single-cycle pulses.
//  - reset: state=ErrRst, timer=0, rx_credit=0, all outputs 0 except link_state=0.
//  - One timer, cleared on every state change, saturates at T_12U8.
//  - ErrRst: rx_resetn=0. timer==T_6U4-1 -> ErrWait.
//  - ErrWait: rx_resetn=1. timer==T_12U8-1 -> Ready.
//  - Ready: (link_start | (auto_start & rx_got_null)) & !link_disable -> Started.
//  - Started: tx_enable=1. rx_got_null -> Connecting; timer==T_12U8-1 -> ErrRst.
//  - Connecting: tx_enable=tx_fct_enable=1. rx_got_fct -> Run; timeout as Started.
//  - Run: tx_enable, tx_fct_enable, tx_data_enable=1; link_running=1.
//  - Error set E = rx_error | disconnect | credit violation. In ErrWait..Run,
//    E -> ErrRst. Run: link_disable -> ErrRst.
//  - ErrWait/Ready/Started: rx_got_fct|rx_got_nchar|rx_got_time_code -> ErrRst.
//    Connecting: rx_got_nchar|rx_got_time_code -> ErrRst.
//  - Priority in a cycle: error/ErrRst transition beats any forward transition.
//  - Disconnect: armed after first rx_got_bit since leaving ErrRst; gap counter
//    cleared by rx_got_bit; reaching T_DISC = disconnect. Disarmed in ErrRst.
//  - Outputs registered: state-derived outputs change the cycle after the event.
//  - Credit (Connecting/Run only): tx_fct_sent adds 8; rx_got_nchar subtracts 1;
//    both in one cycle -> net +7. Add making credit>56, or nchar at credit 0,
//    -> credit_error pulse, credit unchanged, state -> ErrRst.
//  - rx_credit cleared to 0 in ErrRst; never wraps (6-bit, max 56).
//  - link_error pulses once per ErrRst entry from any state (not on reset).
// TESTING
//  - reset, link_start=1, feed NULLs from Started -> states 0,1,2,3,4 with
//    ErrRst for 640 and ErrWait for 1280 cycles; rx_got_fct -> link_state=5.
//  - Started, no rx_got_null for 1280 cycles -> ErrRst, link_error one pulse.
//  - Run, 7 tx_fct_sent -> rx_credit=56; 8th -> credit_error, ErrRst, credit=0.
//  - Run, credit=1: two rx_got_nchar -> credit 0 then credit_error + ErrRst;
//    tx_fct_sent+rx_got_nchar same cycle at 10 -> 17.
//  - Run, rx_got_bit stops 85 cycles -> ErrRst; auto_start only: Ready waits
//    until rx_got_null; rx_got_nchar in ErrWait -> ErrRst.

Source files
------------

// File: rtl/spw_link_fsm_if.sv
// Signal bundle between the SpaceWire link FSM and its rx detector, tx encoder and host.
// The master side drives host controls and detector/encoder events; the slave is the FSM.
interface spw_link_fsm_if;
  logic       link_start;
  logic       auto_start;
  logic       link_disable;
  logic       rx_got_bit;
  logic       rx_got_null;
  logic       rx_got_fct;
  logic       rx_got_nchar;
  logic       rx_got_time_code;
  logic       rx_error;
  logic       tx_fct_sent;
  logic       rx_resetn;
  logic       tx_enable;
  logic       tx_fct_enable;
  logic       tx_data_enable;
  logic [2:0] link_state;
  logic       link_running;
  logic       link_error;
  logic       credit_error;
  logic [5:0] rx_credit;

  modport master (
    output link_start, auto_start, link_disable,
    output rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error,
    output tx_fct_sent,
    input  rx_resetn, tx_enable, tx_fct_enable, tx_data_enable,
    input  link_state, link_running, link_error, credit_error, rx_credit
  );

  modport slave (
    input  link_start, auto_start, link_disable,
    input  rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error,
    input  tx_fct_sent,
    output rx_resetn, tx_enable, tx_fct_enable, tx_data_enable,
    output link_state, link_running, link_error, credit_error, rx_credit
  );
endinterface

// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface state machine: ErrorReset..Run sequencing, disconnect
// detection and receive-credit accounting. All outputs are registered.
module spw_link_fsm #(
  parameter int unsigned T_6U4  = 640,
  parameter int unsigned T_12U8 = 1280,
  parameter int unsigned T_DISC = 85
) (
  input logic           pclk,
  input logic           reset,
  spw_link_fsm_if.slave bus
);

  localparam int unsigned TimerW = $clog2(T_12U8 + 1);
  localparam int unsigned GapW   = $clog2(T_DISC + 1);

  localparam logic [TimerW-1:0] TimerErrRst = TimerW'(T_6U4 - 1);
  localparam logic [TimerW-1:0] TimerLong   = TimerW'(T_12U8 - 1);
  localparam logic [TimerW-1:0] TimerMax    = TimerW'(T_12U8);
  localparam logic [GapW-1:0]   GapLimit    = GapW'(T_DISC - 1);
  localparam logic [6:0]        CreditMax   = 7'd56;

  typedef enum logic [2:0] {
    StErrorReset = 3'd0,
    StErrorWait  = 3'd1,
    StReady      = 3'd2,
    StStarted    = 3'd3,
    StConnecting = 3'd4,
    StRun        = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q;
  logic [GapW-1:0]    gap_q;
  logic               armed_q;
  logic [5:0]         credit_q;

  logic       disconnect, timeout, err_any;
  logic       bad_conn, bad_char;
  logic       credit_state, credit_over, credit_under, credit_viol;
  logic [6:0] credit_inc, credit_net;

  always_comb begin
    credit_inc   = {1'b0, credit_q} + (bus.tx_fct_sent ? 7'd8 : 7'd0);
    credit_net   = credit_inc - {6'd0, bus.rx_got_nchar};
    credit_state = (state_q == StConnecting) || (state_q == StRun);
    credit_over  = bus.tx_fct_sent & (credit_net > CreditMax);
    credit_under = bus.rx_got_nchar & ~bus.tx_fct_sent & (credit_q == 6'd0);
    credit_viol  = credit_state & (credit_over | credit_under);

    // gap_q counts idle cycles before this one, so this cycle is the T_DISC-th
    disconnect = armed_q & ~bus.rx_got_bit & (gap_q == GapLimit);
    err_any    = bus.rx_error | disconnect | credit_viol;
    timeout    = (timer_q == TimerLong);
    bad_conn   = bus.rx_got_nchar | bus.rx_got_time_code;
    bad_char   = bus.rx_got_fct | bad_conn;

    state_d = state_q;
    unique case (state_q)
      StErrorReset: if (timer_q == TimerErrRst) state_d = StErrorWait;
      StErrorWait: begin
        if (err_any || bad_char) state_d = StErrorReset;
        else if (timeout)        state_d = StReady;
      end
      StReady: begin
        if (err_any || bad_char) state_d = StErrorReset;
        else if ((bus.link_start || (bus.auto_start && bus.rx_got_null)) && !bus.link_disable)
          state_d = StStarted;
      end
      StStarted: begin
        if (err_any || bad_char || timeout) state_d = StErrorReset;
        else if (bus.rx_got_null)           state_d = StConnecting;
      end
      StConnecting: begin
        if (err_any || bad_conn || timeout) state_d = StErrorReset;
        else if (bus.rx_got_fct)            state_d = StRun;
      end
      StRun: if (err_any || bus.link_disable) state_d = StErrorReset;
      default: state_d = StErrorReset;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q            <= StErrorReset;
      timer_q            <= '0;
      gap_q              <= '0;
      armed_q            <= 1'b0;
      credit_q           <= '0;
      bus.rx_resetn      <= 1'b0;
      bus.tx_enable      <= 1'b0;
      bus.tx_fct_enable  <= 1'b0;
      bus.tx_data_enable <= 1'b0;
      bus.link_state     <= 3'd0;
      bus.link_running   <= 1'b0;
      bus.link_error     <= 1'b0;
      bus.credit_error   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)     timer_q <= '0;
      else if (timer_q != TimerMax) timer_q <= timer_q + 1'b1;

      if (state_q == StErrorReset) begin
        armed_q <= 1'b0;
        gap_q   <= '0;
      end else if (bus.rx_got_bit) begin
        armed_q <= 1'b1;
        gap_q   <= '0;
      end else if (armed_q && (gap_q != GapLimit)) begin
        gap_q <= gap_q + 1'b1;
      end

      // A violating update is dropped; ErrorReset then clears the count.
      if (state_q == StErrorReset)       credit_q <= '0;
      else if (credit_state && !credit_viol) credit_q <= credit_net[5:0];

      bus.rx_resetn      <= (state_d != StErrorReset);
      bus.tx_enable      <= (state_d == StStarted) || (state_d == StConnecting) ||
                            (state_d == StRun);
      bus.tx_fct_enable  <= (state_d == StConnecting) || (state_d == StRun);
      bus.tx_data_enable <= (state_d == StRun);
      bus.link_state     <= state_d;
      bus.link_running   <= (state_d == StRun);
      bus.link_error     <= (state_d == StErrorReset) && (state_q != StErrorReset);
      bus.credit_error   <= credit_viol;
    end
  end

  assign bus.rx_credit = credit_q;

endmodule

// File: tb/tb_spw_link_fsm.sv
// Randomised bench for spw_link_fsm: a timestamp-based reference model is compared
// against every output each cycle, plus directed checks of the key link scenarios.
module tb_spw_link_fsm;

  localparam int T6   = 640;
  localparam int T12  = 1280;
  localparam int TDIS = 85;

  logic clk = 1'b0;
  logic reset;
  spw_link_fsm_if bus ();

  spw_link_fsm dut (
    .pclk  (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link phase plus timestamps of state entry and last bit edge.
  int m_st, m_cyc, m_enter, m_last_bit, m_credit;
  bit m_armed, m_lerr, m_cerr;

  bit bits_on;
  int bit_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt, dwell;
    bit  disc, cviol, e, badc;
    if (reset) begin
      m_st = 0; m_armed = 0; m_credit = 0; m_lerr = 0; m_cerr = 0;
      m_cyc++;
      m_enter = m_cyc;
      return;
    end
    dwell = m_cyc - m_enter;
    disc  = (m_st != 0) && m_armed && !bus.rx_got_bit && (m_cyc - m_last_bit >= TDIS);
    cviol = 0;
    if (m_st >= 4) begin
      if (bus.tx_fct_sent) cviol = (m_credit + 8 - int'(bus.rx_got_nchar)) > 56;
      else                 cviol = bus.rx_got_nchar && (m_credit == 0);
    end
    e    = bus.rx_error || disc || cviol;
    badc = bus.rx_got_fct || bus.rx_got_nchar || bus.rx_got_time_code;
    nxt  = m_st;
    case (m_st)
      0: if (dwell == T6 - 1) nxt = 1;
      1: if (e || badc) nxt = 0; else if (dwell == T12 - 1) nxt = 2;
      2: if (e || badc) nxt = 0;
         else if ((bus.link_start || (bus.auto_start && bus.rx_got_null)) && !bus.link_disable)
           nxt = 3;
      3: if (e || badc || dwell == T12 - 1) nxt = 0; else if (bus.rx_got_null) nxt = 4;
      4: if (e || bus.rx_got_nchar || bus.rx_got_time_code || dwell == T12 - 1) nxt = 0;
         else if (bus.rx_got_fct) nxt = 5;
      default: if (e || bus.link_disable) nxt = 0;
    endcase
    if (m_st == 0) m_credit = 0;
    else if (m_st >= 4 && !cviol)
      m_credit = m_credit + 8 * int'(bus.tx_fct_sent) - int'(bus.rx_got_nchar);
    if (m_st == 0) m_armed = 0;
    else if (bus.rx_got_bit) begin
      m_armed    = 1;
      m_last_bit = m_cyc;
    end
    m_lerr = (nxt == 0) && (m_st != 0);
    m_cerr = cviol;
    if (nxt != m_st) m_enter = m_cyc + 1;
    m_st = nxt;
    m_cyc++;
  endtask

  function automatic logic [15:0] dut_vec();
    return {bus.rx_resetn, bus.tx_enable, bus.tx_fct_enable, bus.tx_data_enable,
            bus.link_running, bus.link_error, bus.credit_error, bus.link_state, bus.rx_credit};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {m_st != 0, m_st >= 3, m_st >= 4, m_st == 5, m_st == 5, m_lerr, m_cerr,
            3'(m_st), 6'(m_credit)};
  endfunction

  task automatic tick();
    if (bits_on) begin
      if (bit_cnt <= 1) begin
        bus.rx_got_bit = 1'b1;
        bit_cnt = $urandom_range(1, 20);
      end else begin
        bit_cnt--;
      end
    end
    model_step();
    @(posedge clk);
    #1;
    check_eq("outputs", 32'(dut_vec()), 32'(exp_vec()));
    bus.rx_got_bit       = 1'b0;
    bus.rx_got_null      = 1'b0;
    bus.rx_got_fct       = 1'b0;
    bus.rx_got_nchar     = 1'b0;
    bus.rx_got_time_code = 1'b0;
    bus.tx_fct_sent      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset and run to Ready, measuring the ErrorReset and ErrorWait dwell.
  task automatic bring_up(input bit use_auto);
    int n0, n1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.link_start = !use_auto;
    bus.auto_start = use_auto;
    n0 = (bus.link_state == 3'd0) ? 1 : 0;
    n1 = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (bus.link_state == 3'd0)      n0++;
      else if (bus.link_state == 3'd1) n1++;
      else break;
    end
    check_eq("reach_ready", 32'(bus.link_state), 32'd2);
    check_eq("errrst_len", n0, T6);
    check_eq("errwait_len", n1, T12);
  endtask

  task automatic goto_run();
    bring_up(1'b0);
    tick();
    check_eq("started", 32'(bus.link_state), 32'd3);
    bus.rx_got_null = 1'b1;
    tick();
    check_eq("connecting", 32'(bus.link_state), 32'd4);
    bus.rx_got_fct = 1'b1;
    tick();
    check_eq("run", 32'(bus.link_state), 32'd5);
    check_eq("running", 32'(bus.link_running), 32'd1);
  endtask

  initial begin
    int n, nle;
    reset = 1'b1;
    bus.link_start = 0; bus.auto_start = 0; bus.link_disable = 0;
    bus.rx_got_bit = 0; bus.rx_got_null = 0; bus.rx_got_fct = 0; bus.rx_got_nchar = 0;
    bus.rx_got_time_code = 0; bus.rx_error = 0; bus.tx_fct_sent = 0;
    m_cyc = 0; m_enter = 0; m_last_bit = 0; m_st = 0; m_credit = 0;
    bits_on = 1; bit_cnt = 3;

    // Reset state
    tick();
    check_eq("reset_vec", 32'(dut_vec()), 32'd0);

    // Random credit-safe traffic in Run, then link_disable
    goto_run();
    for (int i = 0; i < 300; i++) begin
      if (m_credit <= 40 && $urandom_range(0, 5) == 0) bus.tx_fct_sent = 1'b1;
      if (m_credit > 0 && $urandom_range(0, 2) == 0)   bus.rx_got_nchar = 1'b1;
      if ($urandom_range(0, 15) == 0)                  bus.rx_got_time_code = 1'b1;
      tick();
    end
    check_eq("traffic_run", 32'(bus.link_state), 32'd5);
    bus.link_disable = 1'b1;
    tick();
    check_eq("disable_state", 32'(bus.link_state), 32'd0);
    check_eq("disable_lerr", 32'(bus.link_error), 32'd1);
    bus.link_disable = 1'b0;

    // Credit overflow
    goto_run();
    for (int i = 0; i < 7; i++) begin
      bus.tx_fct_sent = 1'b1;
      tick();
      idle($urandom_range(0, 3));
    end
    check_eq("credit_56", 32'(bus.rx_credit), 32'd56);
    bus.tx_fct_sent = 1'b1;
    tick();
    check_eq("ovf_cerr", 32'(bus.credit_error), 32'd1);
    check_eq("ovf_state", 32'(bus.link_state), 32'd0);
    check_eq("ovf_lerr", 32'(bus.link_error), 32'd1);
    idle(2);
    check_eq("ovf_credit0", 32'(bus.rx_credit), 32'd0);

    // Net +7, then underflow
    goto_run();
    bus.tx_fct_sent = 1'b1; tick();
    bus.tx_fct_sent = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin bus.rx_got_nchar = 1'b1; tick(); end
    check_eq("credit_10", 32'(bus.rx_credit), 32'd10);
    bus.tx_fct_sent = 1'b1; bus.rx_got_nchar = 1'b1; tick();
    check_eq("credit_17", 32'(bus.rx_credit), 32'd17);
    for (int i = 0; i < 16; i++) begin bus.rx_got_nchar = 1'b1; tick(); end
    check_eq("credit_1", 32'(bus.rx_credit), 32'd1);
    bus.rx_got_nchar = 1'b1; tick();
    check_eq("credit_0", 32'(bus.rx_credit), 32'd0);
    check_eq("credit_0_run", 32'(bus.link_state), 32'd5);
    bus.rx_got_nchar = 1'b1; tick();
    check_eq("udf_cerr", 32'(bus.credit_error), 32'd1);
    check_eq("udf_state", 32'(bus.link_state), 32'd0);

    // Started timeout
    bring_up(1'b0);
    n = 0;
    for (int i = 0; i < 1400; i++) begin
      tick();
      if (bus.link_state == 3'd3) n++;
      else break;
    end
    check_eq("started_len", n, T12);
    check_eq("timeout_state", 32'(bus.link_state), 32'd0);
    nle = int'(bus.link_error);
    bus.link_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nle += int'(bus.link_error);
    end
    check_eq("timeout_lerr_once", nle, 1);

    // Disconnect after 85 silent cycles
    goto_run();
    bits_on = 0;
    bus.rx_got_bit = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (bus.link_state == 3'd0) break;
    end
    check_eq("disc_gap", n, TDIS);
    bits_on = 1;

    // rx_error in Run
    goto_run();
    bus.rx_error = 1'b1;
    tick();
    bus.rx_error = 1'b0;
    check_eq("rxerr_state", 32'(bus.link_state), 32'd0);
    check_eq("rxerr_lerr", 32'(bus.link_error), 32'd1);

    // auto_start only: Ready waits for a NULL; link_disable blocks it
    bring_up(1'b1);
    idle(100);
    check_eq("auto_wait", 32'(bus.link_state), 32'd2);
    bus.link_disable = 1'b1;
    bus.rx_got_null  = 1'b1;
    tick();
    check_eq("auto_disabled", 32'(bus.link_state), 32'd2);
    bus.link_disable = 1'b0;
    bus.rx_got_null  = 1'b1;
    tick();
    check_eq("auto_started", 32'(bus.link_state), 32'd3);

    // N-Char in ErrorWait
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.link_start = 1'b0;
    bus.auto_start = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (bus.link_state == 3'd1) break;
    end
    check_eq("errwait", 32'(bus.link_state), 32'd1);
    idle(10);
    bus.rx_got_nchar = 1'b1;
    tick();
    check_eq("ew_nchar_state", 32'(bus.link_state), 32'd0);
    check_eq("ew_nchar_lerr", 32'(bus.link_error), 32'd1);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
